// File: rtl/lsu_data_if.sv
// lsu_data_if: load/store unit front end for the data-memory req/gnt/rvalid bus.
// Accepts one typed access from EX, runs it with one transaction outstanding,
// builds byte enables and lane-rotated store data, and aligns plus extends load data.
// The pipeline is held through lsu_stall_o until lsu_done_o pulses.
//
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN
//   defined   : word-crossing accesses are split into two bus transactions
//   undefined : word-crossing accesses complete at once with lsu_err_o and no bus activity
//
// Ports
//   clk, rst_i                      clock, asynchronous active-high reset
//   lsu_valid_i                     EX access request, held until lsu_done_o
//   load_type_i[2:0]                001 LB, 101 LBU, 010 LH, 110 LHU, 100 LW, 000 none
//   store_type_i[1:0]               01 SB, 10 SH, 11 SW, 00 none
//   addr_i, wdata_i                 effective byte address, LSB-aligned store data
//   lsu_done_o, lsu_err_o           completion pulse, error pulse (with done)
//   lsu_stall_o                     pipeline stall (combinational)
//   lsu_rdata_o                     extended load result, valid with lsu_done_o
//   data_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/rvalid_i/rdata_i   memory bus
module lsu_data_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    lsu_valid_i,
    input  logic [2:0]              load_type_i,
    input  logic [1:0]              store_type_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    lsu_done_o,
    output logic                    lsu_stall_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    output logic                    lsu_err_o,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [3:0]              data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_ERR, S_REQ2, S_WAIT2
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              off_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;
    logic [2:0]              load_type_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                    split_q;
    logic [3:0]              be2_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
`endif

    // Request decode
    logic            is_load, is_store, typed, load_code_ok, crossing, bad, accept;
    logic [1:0]      off, size;
    logic [3:0]      be_first, be_second;
    logic [DATA_WIDTH-1:0] wdata_rot;

    always_comb begin
        off          = addr_i[1:0];
        is_load      = (load_type_i != 3'b000);
        is_store     = (store_type_i != 2'b00);
        typed        = is_load | is_store;
        load_code_ok = (load_type_i == 3'b001) || (load_type_i == 3'b101) ||
                       (load_type_i == 3'b010) || (load_type_i == 3'b110) ||
                       (load_type_i == 3'b100);
        if (is_load)
            size = (load_type_i[1:0] == 2'b01) ? SZ_B :
                   (load_type_i[1:0] == 2'b10) ? SZ_H : SZ_W;
        else
            size = (store_type_i == 2'b01) ? SZ_B :
                   (store_type_i == 2'b10) ? SZ_H : SZ_W;
        crossing = ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
`ifdef LSU_MISALIGNED_SPLIT_EN
        bad = (is_load && is_store) || (is_load && !load_code_ok);
`else
        bad = (is_load && is_store) || (is_load && !load_code_ok) || crossing;
`endif
        accept = (state_q == S_IDLE) && lsu_valid_i && typed;
        // Shifted base mask truncated to 4 bits doubles as the first half of a split
        case (size)
            SZ_B:    be_first = 4'(4'b0001 << off);
            SZ_H:    be_first = 4'(4'b0011 << off);
            default: be_first = 4'(4'b1111 << off);
        endcase
        be_second = (size == SZ_W) ? 4'(4'b1111 >> (3'd4 - 3'(off))) : 4'b0001;
        case (off)
            2'd0:    wdata_rot = wdata_i;
            2'd1:    wdata_rot = {wdata_i[23:0], wdata_i[31:24]};
            2'd2:    wdata_rot = {wdata_i[15:0], wdata_i[31:16]};
            default: wdata_rot = {wdata_i[7:0],  wdata_i[31:8]};
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = bad ? S_ERR : S_REQ;
            S_REQ:  if (data_gnt_i) state_d = S_WAIT;
            S_WAIT: begin
                if (data_rvalid_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = split_q ? S_REQ2 : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_REQ2:  if (data_gnt_i) state_d = S_WAIT2;
            S_WAIT2: if (data_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Access registers, loaded on accept and advanced between split halves
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            off_q       <= 2'd0;
            be_q        <= 4'd0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            load_type_q <= 3'd0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q     <= 1'b0;
            be2_q       <= 4'd0;
            rdata1_q    <= '0;
`endif
        end else if (accept) begin
            addr_q      <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            off_q       <= off;
            be_q        <= be_first;
            wdata_q     <= wdata_rot;
            we_q        <= is_store;
            load_type_q <= load_type_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q     <= crossing;
            be2_q       <= be_second;
`endif
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        else if ((state_q == S_REQ) && data_gnt_i && split_q) begin
            addr_q <= addr_q + ADDR_WIDTH'(4);
            be_q   <= be2_q;
        end else if ((state_q == S_WAIT) && data_rvalid_i && split_q) begin
            rdata1_q <= data_rdata_i;
        end
`endif
    end

    // Load alignment and extension
    logic [2*DATA_WIDTH-1:0] load_win;
    logic [DATA_WIDTH-1:0]   load_sh, load_ext;

    always_comb begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        load_win = split_q ? {data_rdata_i, rdata1_q} : {{DATA_WIDTH{1'b0}}, data_rdata_i};
`else
        load_win = {{DATA_WIDTH{1'b0}}, data_rdata_i};
`endif
        load_sh = DATA_WIDTH'(load_win >> {off_q, 3'b000});
        case (load_type_q)
            3'b001:  load_ext = {{24{load_sh[7]}},  load_sh[7:0]};
            3'b101:  load_ext = {24'd0,             load_sh[7:0]};
            3'b010:  load_ext = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b110:  load_ext = {16'd0,             load_sh[15:0]};
            default: load_ext = load_sh;
        endcase
    end

    // Output logic
    logic rsp_done;

    always_comb begin
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'd0;
        data_wdata_o = '0;
        lsu_err_o    = 1'b0;
        rsp_done     = 1'b0;
        case (state_q)
            S_REQ, S_REQ2: begin
                data_req_o   = 1'b1;
                data_addr_o  = addr_q;
                data_we_o    = we_q;
                data_be_o    = be_q;
                data_wdata_o = wdata_q;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_WAIT:  rsp_done = data_rvalid_i && !split_q;
`else
            S_WAIT:  rsp_done = data_rvalid_i;
`endif
            S_WAIT2: rsp_done = data_rvalid_i;
            S_ERR:   lsu_err_o = 1'b1;
            default: ;
        endcase
        lsu_done_o  = rsp_done | lsu_err_o;
        lsu_rdata_o = (rsp_done && !we_q) ? load_ext : '0;
        lsu_stall_o = lsu_valid_i && typed && !lsu_done_o;
    end

endmodule

// File: tb/tb_lsu_data_if.sv
// Directed self-checking bench for lsu_data_if; runs in both split and non-split builds.
module tb_lsu_data_if;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_valid_i;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic [31:0] addr_i, wdata_i;
    logic        lsu_done_o, lsu_stall_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;

    int checks = 0;
    int errors = 0;

    lsu_data_if dut (
        .clk(clk), .rst_i(rst_i), .lsu_valid_i(lsu_valid_i),
        .load_type_i(load_type_i), .store_type_i(store_type_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .lsu_done_o(lsu_done_o), .lsu_stall_o(lsu_stall_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        lsu_valid_i = 1'b0; load_type_i = 3'b000; store_type_i = 2'b00;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] lt, input logic [31:0] a,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_rd);
        next_cycle(); lsu_valid_i = 1'b1; load_type_i = lt; store_type_i = 2'b00; addr_i = a;
        settle(); chk({tag, "_stall_c0"}, 32'(lsu_stall_o), 32'd1);
        next_cycle(); data_gnt_i = 1'b1;
        settle(); chk({tag, "_req"}, 32'(data_req_o), 32'd1);
        chk({tag, "_be"}, 32'(data_be_o), 32'(exp_be));
        chk({tag, "_addr"}, data_addr_o, a & 32'hFFFF_FFFC);
        chk({tag, "_we"}, 32'(data_we_o), 32'd0);
        next_cycle(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rd;
        settle(); chk({tag, "_done"}, 32'(lsu_done_o), 32'd1);
        chk({tag, "_rdata"}, lsu_rdata_o, exp_rd);
        chk({tag, "_err"}, 32'(lsu_err_o), 32'd0);
        chk({tag, "_stall_done"}, 32'(lsu_stall_o), 32'd0);
        next_cycle(); idle_inputs();
        settle(); chk({tag, "_done_after"}, 32'(lsu_done_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; addr_i = '0; wdata_i = '0; data_rdata_i = '0;
        idle_inputs();
        // Reset state, with stale bus responses present
        next_cycle(); data_rvalid_i = 1'b1; data_gnt_i = 1'b1;
        settle();
        chk("rst_req", 32'(data_req_o), 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_done", 32'(lsu_done_o), 32'd0);
        chk("rst_err", 32'(lsu_err_o), 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        next_cycle(); rst_i = 1'b0;
        next_cycle();
        settle(); chk("idle_stale_done", 32'(lsu_done_o), 32'd0);
        chk("idle_stale_req", 32'(data_req_o), 32'd0);
        next_cycle(); idle_inputs();

        // T1..T2 aligned loads
        do_load("t1_lw", 3'b100, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_load("t2_lb", 3'b001, 32'h103, 32'h80FF_FF00, 4'b1000, 32'hFFFF_FF80);
        do_load("t2_lbu", 3'b101, 32'h103, 32'h80FF_FF00, 4'b1000, 32'h0000_0080);
        do_load("lh", 3'b010, 32'h102, 32'h8001_5555, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 3'b110, 32'h102, 32'h8001_5555, 4'b1100, 32'h0000_8001);
        do_load("lh_off1", 3'b010, 32'h101, 32'h00F0_0F00, 4'b0110, 32'hFFFF_F00F);

        // T3 SH with grant held off 3 cycles
        next_cycle(); lsu_valid_i = 1'b1; store_type_i = 2'b10; addr_i = 32'h202;
        wdata_i = 32'h1234_ABCD;
        settle(); chk("t3_stall_c0", 32'(lsu_stall_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); data_gnt_i = (i == 3);
            settle(); chk("t3_req", 32'(data_req_o), 32'd1);
            chk("t3_be", 32'(data_be_o), 32'hC);
            chk("t3_wdata", data_wdata_o, 32'hABCD_1234);
            chk("t3_we", 32'(data_we_o), 32'd1);
            chk("t3_stall", 32'(lsu_stall_o), 32'd1);
        end
        next_cycle(); data_gnt_i = 1'b0;
        settle(); chk("t3_req_wait", 32'(data_req_o), 32'd0);
        chk("t3_stall_wait", 32'(lsu_stall_o), 32'd1);
        next_cycle(); data_rvalid_i = 1'b1;
        settle(); chk("t3_done", 32'(lsu_done_o), 32'd1);
        chk("t3_rdata_zero", lsu_rdata_o, 32'd0);
        chk("t3_stall_done", 32'(lsu_stall_o), 32'd0);
        next_cycle(); idle_inputs();

        // SB lane rotation
        next_cycle(); lsu_valid_i = 1'b1; store_type_i = 2'b01; addr_i = 32'h301;
        wdata_i = 32'h0000_00AB;
        next_cycle(); data_gnt_i = 1'b1;
        settle(); chk("sb_be", 32'(data_be_o), 32'h2);
        chk("sb_wdata", data_wdata_o, 32'h0000_AB00);
        chk("sb_addr", data_addr_o, 32'h300);
        next_cycle(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        settle(); chk("sb_done", 32'(lsu_done_o), 32'd1);
        next_cycle(); idle_inputs();

        // T4 word-crossing LW
        next_cycle(); lsu_valid_i = 1'b1; load_type_i = 3'b100; addr_i = 32'h101;
`ifdef LSU_MISALIGNED_SPLIT_EN
        next_cycle(); data_gnt_i = 1'b1;
        settle(); chk("t4_req1", 32'(data_req_o), 32'd1);
        chk("t4_be1", 32'(data_be_o), 32'hE);
        chk("t4_addr1", data_addr_o, 32'h100);
        next_cycle(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h4433_2211;
        settle(); chk("t4_done_early", 32'(lsu_done_o), 32'd0);
        chk("t4_stall_mid", 32'(lsu_stall_o), 32'd1);
        next_cycle(); data_rvalid_i = 1'b0; data_gnt_i = 1'b1;
        settle(); chk("t4_req2", 32'(data_req_o), 32'd1);
        chk("t4_be2", 32'(data_be_o), 32'h1);
        chk("t4_addr2", data_addr_o, 32'h104);
        next_cycle(); data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8877_6655;
        settle(); chk("t4_done", 32'(lsu_done_o), 32'd1);
        chk("t4_rdata", lsu_rdata_o, 32'h5544_3322);
        chk("t4_err", 32'(lsu_err_o), 32'd0);
`else
        next_cycle();
        settle(); chk("t4_done", 32'(lsu_done_o), 32'd1);
        chk("t4_err", 32'(lsu_err_o), 32'd1);
        chk("t4_req", 32'(data_req_o), 32'd0);
        chk("t4_rdata", lsu_rdata_o, 32'd0);
`endif
        next_cycle(); idle_inputs();
        settle(); chk("t4_idle_done", 32'(lsu_done_o), 32'd0);

        // T5 both type codes set
        next_cycle(); lsu_valid_i = 1'b1; load_type_i = 3'b010; store_type_i = 2'b10;
        addr_i = 32'h100;
        settle(); chk("t5_req_c0", 32'(data_req_o), 32'd0);
        next_cycle();
        settle(); chk("t5_done", 32'(lsu_done_o), 32'd1);
        chk("t5_err", 32'(lsu_err_o), 32'd1);
        chk("t5_req", 32'(data_req_o), 32'd0);
        next_cycle(); idle_inputs();

        // Valid with no type code is ignored
        next_cycle(); lsu_valid_i = 1'b1;
        settle(); chk("none_stall", 32'(lsu_stall_o), 32'd0);
        next_cycle();
        settle(); chk("none_done", 32'(lsu_done_o), 32'd0);
        chk("none_req", 32'(data_req_o), 32'd0);
        next_cycle(); idle_inputs();

        // T6 reset during WAIT_RVALID
        next_cycle(); lsu_valid_i = 1'b1; load_type_i = 3'b100; addr_i = 32'h100;
        next_cycle(); data_gnt_i = 1'b1;
        next_cycle(); data_gnt_i = 1'b0;
        settle(); chk("t6_wait_req", 32'(data_req_o), 32'd0);
        rst_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
        settle(); chk("t6_rst_done", 32'(lsu_done_o), 32'd0);
        chk("t6_rst_req", 32'(data_req_o), 32'd0);
        next_cycle(); rst_i = 1'b0; lsu_valid_i = 1'b0; load_type_i = 3'b000;
        settle(); chk("t6_late_done", 32'(lsu_done_o), 32'd0);
        chk("t6_late_rdata", lsu_rdata_o, 32'd0);
        next_cycle(); idle_inputs();
        do_load("t6_lw", 3'b100, 32'h100, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
